bus_master: RTL and testbench

Bus initiator for the shared `sysbus`, and the master-side counterpart of the synchronous MAR/MDR memory. It turns a single-word client request (`req`/`ack`) into the correct sequence of `load_MAR`, `load_MDR`, `CS`, `R_NW` and `MDR_bus` strobes. It also drives the address and write data onto `sysbus` and captures read data from it. It sits beside the CPU sequencer and must win bus ownership through `bus_req`/`bus_gnt` before it issues any strobe.

---
 rtl/bus_master.sv | 165 ++++++++++++++++
 tb/tb_bus_master.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_master.sv
// -----------------------------------------------------------------------------
// bus_master
//   Bus initiator for the shared sysbus. It turns one client request (req/ack)
//   into the MAR/MDR memory strobe sequence and drives the address and write
//   data onto sysbus. Read data is captured from sysbus during the MDR_bus
//   cycle. Bus ownership is won through bus_req/bus_gnt before any strobe.
//
//   Parameters
//     WORD_W  : sysbus / data width
//     OP_W    : opcode width; address width A_W = WORD_W-OP_W.
//               addr[A_W-1]=1 selects RAM, addr[A_W-1]=0 selects ROM.
//
//   Ports
//     clock, reset          : rising-edge clock, synchronous active-high reset
//     req/write/addr/wdata  : client request, captured when accepted in IDLE
//     ack, rdata, err       : completion pulse, last read data, write fault
//     bus_req, bus_gnt      : ownership handshake with the arbiter
//     load_MAR, load_MDR,
//     CS, R_NW, MDR_bus     : memory control strobes (Moore-decoded)
//     sysbus                : shared tri-state bus
//
//   Optional feature: define BUS_MASTER_WPROT_EN to fault writes aimed at the
//   ROM half (no bus cycle, ack+err one cycle after acceptance). Without it,
//   err is tied to 0 and ROM writes run the normal sequence.
// -----------------------------------------------------------------------------
module bus_master #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     write,
  input  logic [WORD_W-OP_W-1:0]   addr,
  input  logic [WORD_W-1:0]        wdata,
  output logic                     ack,
  output logic [WORD_W-1:0]        rdata,
  output logic                     err,
  output logic                     bus_req,
  input  logic                     bus_gnt,
  output logic                     load_MAR,
  output logic                     load_MDR,
  output logic                     CS,
  output logic                     R_NW,
  output logic                     MDR_bus,
  inout  wire  [WORD_W-1:0]        sysbus
);

  localparam int A_W = WORD_W - OP_W;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_DATA, S_ACC, S_RD, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [A_W-1:0]      addr_q,  addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;

  logic                drv_en;
  logic [WORD_W-1:0]   drv_val;

  // Next-state and request capture
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          write_d = write;
          addr_d  = addr;
          wdata_d = wdata;
`ifdef BUS_MASTER_WPROT_EN
          // ROM-half writes never touch the bus; fault straight away
          if (write && !addr[A_W-1]) state_d = S_DONE;
          else                       state_d = S_REQ;
`else
          state_d = S_REQ;
`endif
        end
      end
      S_REQ:  if (bus_gnt) state_d = S_ADDR;
      S_ADDR: state_d = write_q ? S_DATA : S_ACC;
      S_DATA: state_d = S_ACC;
      S_ACC:  state_d = write_q ? S_DONE : S_RD;
      S_RD: begin
        // memory drives MDR onto sysbus this cycle
        rdata_d = sysbus;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    bus_req  = 1'b0;
    load_MAR = 1'b0;
    load_MDR = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b1;
    MDR_bus  = 1'b0;
    ack      = 1'b0;
    drv_en   = 1'b0;
    drv_val  = '0;
    case (state_q)
      S_REQ:  bus_req = 1'b1;
      S_ADDR: begin
        bus_req  = 1'b1;
        load_MAR = 1'b1;
        drv_en   = 1'b1;
        drv_val  = {{OP_W{1'b0}}, addr_q};
      end
      S_DATA: begin
        bus_req  = 1'b1;
        load_MDR = 1'b1;
        drv_en   = 1'b1;
        drv_val  = wdata_q;
      end
      S_ACC: begin
        bus_req = 1'b1;
        CS      = 1'b1;
        R_NW    = ~write_q;
      end
      S_RD: begin
        bus_req = 1'b1;
        MDR_bus = 1'b1;
      end
      S_DONE: ack = 1'b1;
      default: ;
    endcase
  end

`ifdef BUS_MASTER_WPROT_EN
  // only a protected write can reach DONE as a ROM-half write
  assign err = (state_q == S_DONE) && write_q && !addr_q[A_W-1];
`else
  assign err = 1'b0;
`endif

  assign sysbus = drv_en ? drv_val : {WORD_W{1'bz}};
  assign rdata  = rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// -----------------------------------------------------------------------------
// tb_bus_master
//   Drives client transactions into bus_master, emulates the MAR/MDR memory
//   and a stalling arbiter, and checks each ack against a queue of expected
//   responses produced by a word-level memory model.
// -----------------------------------------------------------------------------
module tb_bus_master;
  localparam int WORD_W = 8;
  localparam int OP_W   = 3;
  localparam int A_W    = WORD_W - OP_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req = 1'b0, write = 1'b0, bus_gnt = 1'b0;
  logic [A_W-1:0]    addr = '0;
  logic [WORD_W-1:0] wdata = '0;
  logic              ack, err, bus_req, load_MAR, load_MDR, CS, R_NW, MDR_bus;
  logic [WORD_W-1:0] rdata;
  wire  [WORD_W-1:0] sysbus;

  bus_master #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
    .clock(clock), .reset(reset), .req(req), .write(write), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .load_MAR(load_MAR), .load_MDR(load_MDR), .CS(CS),
    .R_NW(R_NW), .MDR_bus(MDR_bus), .sysbus(sysbus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    if (i == 16) return 8'h11;
    if (i == 17) return 8'h22;
    return 8'(i * 29 + 7);
  endfunction

  // ---- memory responder (RAM half writable, ROM half read-only) ----
  logic [7:0]     mem [32];
  logic [A_W-1:0] mar;
  logic [7:0]     mdr;
  assign sysbus = MDR_bus ? mdr : 8'hzz;
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else begin
      if (load_MAR) mar <= sysbus[A_W-1:0];
      if (load_MDR) mdr <= sysbus;
      if (CS && !R_NW && mar[A_W-1]) mem[mar] <= mdr;
      if (CS && R_NW) mdr <= mem[mar];
    end
  end

  // ---- reference model + scoreboard ----
  typedef struct { logic [7:0] rd; logic er; int c; } exp_t;
  exp_t           sbq[$];
  logic [7:0]     ref_mem [32];
  logic [7:0]     ref_rdata;
  logic           cur_w;
  logic [A_W-1:0] cur_a;
  logic [7:0]     cur_d;
  int             timeouts = 0;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // monitor: protocol checks every cycle, ack checks against the queue
  initial begin : monitor
    logic prev_rst;
    int   seen_to;
    exp_t e;
    prev_rst = 1'b0;
    seen_to  = 0;
    forever begin
      @(negedge clock);
      if (prev_rst) begin
        chk("rst_strobes", {load_MAR, load_MDR, CS, MDR_bus}, 4'b0);
        chk("rst_r_nw", R_NW, 1'b1);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_ack_err", {ack, err}, 2'b0);
        chk("rst_rdata", rdata, 8'h00);
      end
      prev_rst = reset;
      chk("one_strobe", ($countones({load_MAR, load_MDR, CS, MDR_bus}) <= 1), 1'b1);
      if (!bus_req) chk("strobe_wo_busreq", {load_MAR, load_MDR, CS, MDR_bus}, 4'b0);
      if (load_MAR) chk("addr_on_bus", sysbus, {3'b000, cur_a});
      if (load_MDR) chk("wdata_on_bus", sysbus, cur_d);
      if (CS) chk("r_nw_in_acc", R_NW, !cur_w);
      if (err && !ack) chk("err_wo_ack", err, 1'b0);
      if (ack) begin
        if (sbq.size() == 0) chk("unexpected_ack", ack, 1'b0);
        else begin
          e = sbq.pop_front();
          chk("ack_cycle", cyc, e.c);
          chk("rdata", rdata, e.rd);
          chk("err", err, e.er);
        end
      end
      while (seen_to < timeouts) begin
        seen_to++;
        chk("timeout", 1'b1, 1'b0);
      end
    end
  end

  task automatic ref_reset();
    ref_rdata = 8'h00;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
  endtask

  // Issue one transaction. b2b: req is already high from the previous one
  // and the DUT is in its ack cycle now. keep: leave req high after ack.
  task automatic issue(input bit w, input logic [A_W-1:0] a, input logic [7:0] d,
                       input int n, input bit b2b, input bit keep);
    int   acc, r;
    bit   prot, got;
    exp_t e;
    if (!b2b) begin @(posedge clock); #1; end
    acc = b2b ? cyc + 1 : cyc;
    req = 1'b1; write = w; addr = a; wdata = d;
    cur_w = w; cur_a = a; cur_d = d;
    prot = 1'b0;
`ifdef BUS_MASTER_WPROT_EN
    prot = w && !a[A_W-1];
`endif
    if (!w) ref_rdata = ref_mem[a];
    else if (a[A_W-1]) ref_mem[a] = d;
    e.rd = ref_rdata;
    e.er = prot;
    e.c  = acc + (prot ? 1 : 5 + n);
    sbq.push_back(e);
    bus_gnt = (n == 0);
    r = 0;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clock); #1;
      if (ack) got = 1'b1;
      else begin
        if (bus_req) r++;
        bus_gnt = (r > n);
      end
    end
    if (!got) timeouts++;
    if (!keep) req = 1'b0;
  endtask

  initial begin : driver
    bit keep, prev_keep;
    ref_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // directed: write then read, grant stall, back-to-back, ROM write
    issue(1'b1, 5'h13, 8'h5A, 0, 1'b0, 1'b0);
    issue(1'b0, 5'h13, 8'h00, 0, 1'b0, 1'b0);
    issue(1'b0, 5'h13, 8'h00, 4, 1'b0, 1'b0);
    issue(1'b0, 5'h10, 8'h00, 0, 1'b0, 1'b1);
    issue(1'b0, 5'h11, 8'h00, 0, 1'b1, 1'b0);
    issue(1'b1, 5'h03, 8'hA5, 0, 1'b0, 1'b0);
    issue(1'b0, 5'h03, 8'h00, 1, 1'b0, 1'b0);

    // reset during ACC of a read: no ack, back to idle, rdata cleared
    @(posedge clock); #1;
    req = 1'b1; write = 1'b0; addr = 5'h12;
    cur_w = 1'b0; cur_a = 5'h12; cur_d = 8'h00; bus_gnt = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(posedge clock); #1;
        if (CS) seen = 1'b1;
      end
      if (!seen) timeouts++;
    end
    reset = 1'b1; req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    ref_reset();
    repeat (3) @(posedge clock);

    // random traffic
    prev_keep = 1'b0;
    for (int i = 0; i < 80; i++) begin
      keep = (i != 79) && ($urandom_range(0, 2) == 0);
      if (!prev_keep) repeat ($urandom_range(0, 2)) @(posedge clock);
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom),
            $urandom_range(0, 3), prev_keep, keep);
      prev_keep = keep;
    end

    repeat (3) @(posedge clock);
    if (sbq.size() != 0) timeouts++;
    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
